// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser serial-to-parallel path.
// Bit-order encoding and counter sizing live here.
package sipo_pkg;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } bit_order_e;

  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// One-word valid/ready holding register for sipo_deser.
// Loads completed words, hands them off, flags drops.
module sipo_out_stage
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             word_done,
  input  logic [WIDTH-1:0] word,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             overflow
);

  logic stall;

  assign stall = m_valid && !m_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      m_valid  <= 1'b0;
      overflow <= 1'b0;
    end else if (word_done) begin
      // A held, unaccepted word wins; the new one is dropped.
      if (stall) begin
        overflow <= 1'b1;
      end else begin
        m_data  <= word;
        m_valid <= 1'b1;
      end
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserializer with per-word
// bit order and a registered valid/ready output stage.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter bit DEF_LSB_FIRST = 1'b0,
  parameter int CNT_W         = calc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             s_en,
  input  logic             serial_in,
  input  logic             lsb_first,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [WIDTH-1:0] mon_shift,
  output logic             overflow
);

  localparam bit_order_e DEF_ORDER = bit_order_e'(DEF_LSB_FIRST);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nxt;
  logic [CNT_W-1:0] cnt_q;
  bit_order_e       order_q;
  bit_order_e       order_eff;
  logic             accept;
  logic             start;
  logic             done;

  assign accept = s_en && !clear;
  assign start  = (cnt_q == '0);
  assign done   = accept && (cnt_q == LAST);

  // The first bit of a word uses the freshly sampled order.
  assign order_eff = start ? bit_order_e'(lsb_first) : order_q;

  always_comb begin
    shift_nxt = shift_q;
    unique case (order_eff)
      LSB_FIRST: shift_nxt = {serial_in, shift_q[WIDTH-1:1]};
      MSB_FIRST: shift_nxt = {shift_q[WIDTH-2:0], serial_in};
      default:   shift_nxt = shift_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
      order_q <= DEF_ORDER;
    end else if (accept) begin
      shift_q <= shift_nxt;
      order_q <= order_eff;
      cnt_q   <= done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  sipo_out_stage #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .word_done(done),
    .word     (shift_nxt),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .overflow (overflow)
  );

  assign bit_cnt   = cnt_q;
  assign mon_shift = shift_q;

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Parametrised serial-in/parallel-out deserializer. Successor to the fixed 4-bit SIPO shifter.
- Collects WIDTH serial bits, gated by an enable, into a word. Bit order (MSB-first or LSB-first) is selectable per word.
- Presents each word on a valid/ready output stage with a one-word holding register.
- Sits between a bit-serial receiver front end and word-wide datapath logic. Monitor and overflow outputs support debug.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..64.
- DEF_LSB_FIRST, 0: bit order used when clear/reset occurs; informational only, since the order actually used is latched from lsb_first at each word start.
- CNT_W, $clog2(WIDTH+1): bit-counter width; derived, not overridden.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, synchronous, active-low (asserted when 0).
- clear  input  1  synchronous flush, active-high.
- s_en  input  1  serial_in is sampled this cycle.
- serial_in  input  1  serial data bit.
- lsb_first  input  1  bit order for the next word; sampled only at word start.
- m_valid  output  1  m_data holds an unconsumed word.
- m_ready  input  1  consumer accepts m_data.
- m_data  output  WIDTH  assembled word.
- bit_cnt  output  CNT_W  bits collected in the current partial word, 0..WIDTH-1.
- mon_shift  output  WIDTH  raw shift register contents (debug).
- overflow  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (rst==0 at a rising edge):
  - shift register, bit_cnt, m_data, m_valid and overflow all go to 0.
  - Latched order goes to DEF_LSB_FIRST.
  - rst has priority over clear.
- clear==1 (rst==1): same effect as reset, except m_data is not required to change. Any s_en bit in that cycle is discarded.
- Accept: a bit is taken at an edge where s_en==1, rst==1 and clear==0. The input stream cannot be stalled; there is no s_ready.
- Order latch: when a bit is accepted with bit_cnt==0, the latched order takes lsb_first, and that bit uses the new order.
- MSB-first: shift <= {shift[WIDTH-2:0], serial_in}. The first bit ends in bit WIDTH-1.
- LSB-first: shift <= {serial_in, shift[WIDTH-1:1]}. The first bit ends in bit 0.
- bit_cnt increments per accepted bit and wraps from WIDTH-1 to 0 on the completing bit.
- Word completion: the accepted bit arrives with bit_cnt==WIDTH-1.
  - The completed word, including that bit, is the candidate for m_data at the same edge.
  - Latency: m_valid is 1 in the cycle after the last bit is accepted. Back-to-back words at one bit per cycle are sustained when m_ready is held at 1.
- Output stage:
  - Transfer occurs when m_valid && m_ready. m_valid clears at that edge unless a new word completes at the same edge.
  - If a new word completes at the same edge, m_data loads the new word and m_valid stays 1.
  - m_data is stable while m_valid && !m_ready.
- Overflow:
  - Condition: a word completes while m_valid==1 && m_ready==0.
  - The new word is discarded, m_data and m_valid are unchanged, and overflow is set.
  - bit_cnt still wraps to 0.
  - overflow stays set until rst or clear.
- Partial word: with s_en==0, state holds indefinitely. No timeout.
- Changing lsb_first mid-word has no effect until the next word start.
- m_ready is ignored when m_valid==0.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package sipo_pkg: typedef enum logic {MSB_FIRST=0, LSB_FIRST=1} bit_order_e; a function calc_cnt_w(width).
- One sub-module, sipo_out_stage: parametrised by WIDTH. Holds m_data/m_valid, performs load/transfer/overflow detection, and takes a word-complete strobe plus the word.
- Top level: shift register, counter and order latch.

Test Plan:
1. WIDTH=4, MSB-first, m_ready=1, stream 1,0,1,1 on consecutive cycles → m_valid=1 with m_data=4'b1011 one cycle after the 4th bit; bit_cnt sequence 0,1,2,3,0.
2. WIDTH=8, lsb_first=1, stream 0xA5 LSB-first (1,0,1,0,0,1,0,1) → m_data=8'hA5. Then toggle lsb_first to 0 at bit 3 of the next word → that word still assembles LSB-first.
3. WIDTH=4, m_ready=0, send 8 bits (1100 then 0011) → m_data stays 4'b1100 and overflow=1. Raise m_ready → one transfer, then m_valid=0.
4. WIDTH=4, m_ready=1, continuous 12-bit stream with s_en gaps of 2 cycles after bit 2 → three words, no overflow; bit_cnt holds during the gaps.
5. Send 2 bits, pulse clear together with s_en=1 → bit_cnt=0, mon_shift=0, m_valid=0, overflow=0; the next 4 bits form a clean word.
6. Drive rst=0 mid-word with clear=1 simultaneously → all outputs 0 at the next edge. Check rst is synchronous: no change before the clock edge.
